// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the pipeline writeback
//   stage and a variable-latency long-op unit. Long-op results wait in a small
//   FIFO until the port is free. A per-register busy scoreboard stalls decode
//   on RAW/WAW hazards against long ops that are still outstanding.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   wb_en/wb_addr/wb_data           pipeline writeback (never back-pressured)
//   lu_valid/lu_ready/lu_addr/lu_data  long-op result handshake
//   issue_en/issue_addr             long op issued; marks destination busy
//   chk_addr1/chk_addr2/chk_wen/chk_waddr  decode hazard check inputs
//   stall                           decode must hold
//   RegWrite/WriteRegister/WriteData   register-file write port
//   idle                            nothing busy and FIFO empty
//   err                             sticky: issue to an already-busy register
module regfile_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  input  logic              chk_wen,
  input  logic [ADDR_W-1:0] chk_waddr,
  output logic              stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              idle,
  output logic              err
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NREG - 1);

  // The top bit stands for the zero register; it is held at 0 so that hazard
  // lookups on register 31 never stall without special-casing the index.
  logic [NREG-1:0]   busy_q, busy_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic              wb_take;
  logic              fifo_pop;
  logic              lu_push;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // Writes to the zero register are discarded, so they never claim the port.
  assign wb_take  = wb_en && (wb_addr != ZERO_REG);
  assign fifo_pop = !wb_take && (count_q != '0);
  // Depends on registered count only, so the long-op unit sees no comb path
  // from its own valid back into ready.
  assign lu_ready = (count_q < CNT_W'(FIFO_DEPTH));
  // Results for the zero register are accepted and dropped.
  assign lu_push  = lu_valid && lu_ready && (lu_addr != ZERO_REG);

  // Write-port mux
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    if (!reset_n) begin
      RegWrite = 1'b0;
    end else if (wb_take) begin
      RegWrite      = 1'b1;
      WriteRegister = wb_addr;
      WriteData     = wb_data;
    end else if (count_q != '0) begin
      RegWrite      = 1'b1;
      WriteRegister = head_addr;
      WriteData     = head_data;
    end
  end

  // FIFO bookkeeping and scoreboard
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(fifo_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(lu_push);
    count_d  = count_q + CNT_W'(lu_push) - CNT_W'(fifo_pop);
    busy_d   = busy_q;
    err_d    = err_q;
    if (fifo_pop) begin
      busy_d[head_addr] = 1'b0;
    end
    // Applied after the drain clear so a same-cycle set on the same register wins.
    if (issue_en && (issue_addr != ZERO_REG)) begin
      if (busy_q[issue_addr]) begin
        err_d = 1'b1;
      end
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[NREG-1] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (lu_push) begin
      fifo_addr_q[wr_ptr_q] <= lu_addr;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign stall = busy_q[chk_addr1] | busy_q[chk_addr2] | (chk_wen & busy_q[chk_waddr]);
  assign idle  = (busy_q == '0) && (count_q == '0);
  assign err   = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenario tasks plus a randomized
// run checked against a transaction-level model (queue of pending results,
// array of busy flags).
module tb_regfile_wb_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] chk_addr1, chk_addr2, chk_waddr;
  logic          chk_wen;
  logic          stall;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          idle;
  logic          err;

  int chk_pass  = 0;
  int chk_total = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_wen(chk_wen), .chk_waddr(chk_waddr),
    .stall(stall), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .idle(idle), .err(err)
  );

  task automatic idle_inputs();
    wb_en = 0; wb_addr = 0; wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
    issue_en = 0; issue_addr = 0;
    chk_addr1 = 31; chk_addr2 = 31; chk_wen = 0; chk_waddr = 31;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    $display("reset: RegWrite=%0d lu_ready=%0d idle=%0d stall=%0d err=%0d", RegWrite, lu_ready, idle, stall, err);
    chk_total++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got %0d exp 0", RegWrite); else chk_pass++;
    chk_total++; if (lu_ready !== 1'b1) $display("FAIL reset_lu_ready got %0d exp 1", lu_ready); else chk_pass++;
    chk_total++; if (idle !== 1'b1) $display("FAIL reset_idle got %0d exp 1", idle); else chk_pass++;
    chk_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %0d exp 0", stall); else chk_pass++;
    chk_total++; if (err !== 1'b0) $display("FAIL reset_err got %0d exp 0", err); else chk_pass++;
  endtask

  task automatic test_long_op();
    do_reset();
    chk_addr1 = 5;
    issue_en = 1; issue_addr = 5;
    tick();
    issue_en = 0;
    lu_valid = 1; lu_addr = 5; lu_data = 64'hA0;
    #1;
    chk_total++; if (stall !== 1'b1) $display("FAIL longop_stall_pending got %0d exp 1", stall); else chk_pass++;
    chk_total++; if (RegWrite !== 1'b0) $display("FAIL longop_no_write_yet got %0d exp 0", RegWrite); else chk_pass++;
    tick();
    lu_valid = 0;
    #1;
    $display("longop: RegWrite=%0d WriteRegister=%0d WriteData=%0h stall=%0d", RegWrite, WriteRegister, WriteData, stall);
    chk_total++; if (RegWrite !== 1'b1) $display("FAIL longop_regwrite got %0d exp 1", RegWrite); else chk_pass++;
    chk_total++; if (WriteRegister !== 5'd5) $display("FAIL longop_waddr got %0d exp 5", WriteRegister); else chk_pass++;
    chk_total++; if (WriteData !== 64'hA0) $display("FAIL longop_wdata got %0h exp a0", WriteData); else chk_pass++;
    chk_total++; if (stall !== 1'b1) $display("FAIL longop_stall_at_write got %0d exp 1", stall); else chk_pass++;
    tick();
    chk_total++; if (stall !== 1'b0) $display("FAIL longop_stall_release got %0d exp 0", stall); else chk_pass++;
    chk_total++; if (idle !== 1'b1) $display("FAIL longop_idle got %0d exp 1", idle); else chk_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    wb_en = 1; wb_addr = 3; wb_data = 64'h11;
    lu_valid = 1; lu_addr = 7; lu_data = 64'h22;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin lu_addr = 8; lu_data = 64'h33; end
      if (c == 2) lu_valid = 0;
      #1;
      $display("collision cyc%0d: RegWrite=%0d WriteRegister=%0d WriteData=%0h lu_ready=%0d", c, RegWrite, WriteRegister, WriteData, lu_ready);
      chk_total++; if (WriteRegister !== 5'd3 || WriteData !== 64'h11 || RegWrite !== 1'b1)
        $display("FAIL collision_wb%0d got %0d/%0h exp 3/11", c, WriteRegister, WriteData); else chk_pass++;
      chk_total++; if (lu_ready !== (c < 2)) $display("FAIL collision_ready%0d got %0d exp %0d", c, lu_ready, c < 2); else chk_pass++;
      tick();
    end
    wb_en = 0;
    #1;
    chk_total++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 64'h22)
      $display("FAIL collision_drain7 got %0d/%0h exp 7/22", WriteRegister, WriteData); else chk_pass++;
    tick();
    chk_total++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd8 || WriteData !== 64'h33)
      $display("FAIL collision_drain8 got %0d/%0h exp 8/33", WriteRegister, WriteData); else chk_pass++;
    chk_total++; if (lu_ready !== 1'b1) $display("FAIL collision_ready_after got %0d exp 1", lu_ready); else chk_pass++;
    tick();
    chk_total++; if (RegWrite !== 1'b0) $display("FAIL collision_empty got %0d exp 0", RegWrite); else chk_pass++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    lu_valid = 1; lu_addr = 9; lu_data = 64'h99;
    tick();
    lu_valid = 0;
    wb_en = 1; wb_addr = 31; wb_data = 64'hFF;
    #1;
    $display("zero: wb31+head9 RegWrite=%0d WriteRegister=%0d WriteData=%0h", RegWrite, WriteRegister, WriteData);
    chk_total++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 64'h99)
      $display("FAIL zero_wb31_drain got %0d/%0h exp 9/99", WriteRegister, WriteData); else chk_pass++;
    tick();
    wb_en = 0;
    lu_valid = 1; lu_addr = 31; lu_data = 64'h55;
    #1;
    chk_total++; if (lu_ready !== 1'b1) $display("FAIL zero_lu31_ready got %0d exp 1", lu_ready); else chk_pass++;
    tick();
    lu_valid = 0;
    #1;
    chk_total++; if (RegWrite !== 1'b0) $display("FAIL zero_lu31_nowrite got %0d exp 0", RegWrite); else chk_pass++;
    issue_en = 1; issue_addr = 31;
    chk_addr1 = 31; chk_addr2 = 31; chk_wen = 1; chk_waddr = 31;
    tick();
    issue_en = 0;
    #1;
    chk_total++; if (idle !== 1'b1) $display("FAIL zero_issue31_idle got %0d exp 1", idle); else chk_pass++;
    chk_total++; if (stall !== 1'b0) $display("FAIL zero_chk31_stall got %0d exp 0", stall); else chk_pass++;
    chk_total++; if (err !== 1'b0) $display("FAIL zero_issue31_err got %0d exp 0", err); else chk_pass++;
  endtask

  task automatic test_double_issue();
    do_reset();
    issue_en = 1; issue_addr = 4;
    tick();
    #1;
    chk_total++; if (err !== 1'b0) $display("FAIL dbl_first_err got %0d exp 0", err); else chk_pass++;
    tick();
    issue_en = 0;
    lu_valid = 1; lu_addr = 4; lu_data = 64'h4;
    #1;
    chk_total++; if (err !== 1'b1) $display("FAIL dbl_err_set got %0d exp 1", err); else chk_pass++;
    tick();
    lu_valid = 0;
    tick(); tick();
    $display("double issue: err=%0d idle=%0d", err, idle);
    chk_total++; if (err !== 1'b1) $display("FAIL dbl_err_sticky got %0d exp 1", err); else chk_pass++;
    chk_total++; if (idle !== 1'b1) $display("FAIL dbl_idle_after_drain got %0d exp 1", idle); else chk_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue_en = 1; issue_addr = 6;
    tick();
    issue_en = 0;
    lu_valid = 1; lu_addr = 6; lu_data = 64'h66;
    tick();
    lu_valid = 0;
    issue_en = 1; issue_addr = 6;
    #1;
    chk_total++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd6) $display("FAIL same_drain got %0d/%0d exp 1/6", RegWrite, WriteRegister); else chk_pass++;
    tick();
    issue_en = 0;
    chk_addr1 = 6;
    #1;
    $display("same cycle: stall=%0d idle=%0d", stall, idle);
    chk_total++; if (stall !== 1'b1) $display("FAIL same_busy_kept got %0d exp 1", stall); else chk_pass++;
    chk_total++; if (idle !== 1'b0) $display("FAIL same_not_idle got %0d exp 0", idle); else chk_pass++;
  endtask

  task automatic test_waw();
    do_reset();
    issue_en = 1; issue_addr = 12;
    tick();
    issue_en = 0;
    chk_wen = 1; chk_waddr = 12;
    #1;
    chk_total++; if (stall !== 1'b1) $display("FAIL waw_stall got %0d exp 1", stall); else chk_pass++;
    chk_wen = 0;
    #1;
    $display("waw: chk_wen=0 stall=%0d", stall);
    chk_total++; if (stall !== 1'b0) $display("FAIL waw_nowen got %0d exp 0", stall); else chk_pass++;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    wb_en = 1; wb_addr = 3; wb_data = 64'h1;
    lu_valid = 1; lu_addr = 10; lu_data = 64'hA;
    tick();
    lu_addr = 11;
    tick();
    lu_valid = 0;
    #1;
    chk_total++; if (lu_ready !== 1'b0) $display("FAIL midrst_full got %0d exp 0", lu_ready); else chk_pass++;
    reset_n = 0;
    #1;
    $display("mid reset: idle=%0d lu_ready=%0d RegWrite=%0d", idle, lu_ready, RegWrite);
    chk_total++; if (idle !== 1'b1) $display("FAIL midrst_idle got %0d exp 1", idle); else chk_pass++;
    chk_total++; if (lu_ready !== 1'b1) $display("FAIL midrst_ready got %0d exp 1", lu_ready); else chk_pass++;
    chk_total++; if (RegWrite !== 1'b0) $display("FAIL midrst_regwrite got %0d exp 0", RegWrite); else chk_pass++;
    tick();
    reset_n = 1;
    wb_en = 0;
    tick();
    chk_total++; if (RegWrite !== 1'b0) $display("FAIL midrst_discarded got %0d exp 0", RegWrite); else chk_pass++;
  endtask

  task automatic test_random();
    ent_t          mq[$];
    logic          mb[32];
    logic          merr;
    logic          e_rw, e_stall, e_idle, e_ready, wbv, pre_busy;
    logic [AW-1:0] e_wr;
    logic [DW-1:0] e_wd;
    int            nbad;
    do_reset();
    foreach (mb[i]) mb[i] = 0;
    merr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      wb_en      = ($urandom_range(0, 99) < 45);
      wb_addr    = AW'($urandom_range(0, 31));
      wb_data    = {$urandom, $urandom};
      lu_valid   = ($urandom_range(0, 99) < 50);
      lu_addr    = AW'($urandom_range(0, 31));
      lu_data    = {$urandom, $urandom};
      issue_en   = ($urandom_range(0, 99) < 15);
      issue_addr = AW'($urandom_range(0, 31));
      chk_addr1  = AW'($urandom_range(0, 31));
      chk_addr2  = AW'($urandom_range(0, 31));
      chk_wen    = 1'($urandom_range(0, 1));
      chk_waddr  = AW'($urandom_range(0, 31));
      #1;
      // Expected outputs from the model's current state.
      wbv     = wb_en && (wb_addr != 31);
      e_ready = (mq.size() < 2);
      e_rw = 0; e_wr = 0; e_wd = 0;
      if (wbv) begin e_rw = 1; e_wr = wb_addr; e_wd = wb_data; end
      else if (mq.size() > 0) begin e_rw = 1; e_wr = mq[0].a; e_wd = mq[0].d; end
      e_stall = (chk_addr1 != 31 && mb[chk_addr1]) || (chk_addr2 != 31 && mb[chk_addr2]) ||
                (chk_wen && chk_waddr != 31 && mb[chk_waddr]);
      e_idle = (mq.size() == 0);
      foreach (mb[i]) if (mb[i]) e_idle = 0;
      nbad = 0;
      chk_total++; if (RegWrite !== e_rw) begin $display("FAIL rnd_regwrite cyc%0d got %0d exp %0d", cyc, RegWrite, e_rw); nbad++; end else chk_pass++;
      chk_total++; if (WriteRegister !== e_wr) begin $display("FAIL rnd_waddr cyc%0d got %0d exp %0d", cyc, WriteRegister, e_wr); nbad++; end else chk_pass++;
      chk_total++; if (WriteData !== e_wd) begin $display("FAIL rnd_wdata cyc%0d got %0h exp %0h", cyc, WriteData, e_wd); nbad++; end else chk_pass++;
      chk_total++; if (lu_ready !== e_ready) begin $display("FAIL rnd_lu_ready cyc%0d got %0d exp %0d", cyc, lu_ready, e_ready); nbad++; end else chk_pass++;
      chk_total++; if (stall !== e_stall) begin $display("FAIL rnd_stall cyc%0d got %0d exp %0d", cyc, stall, e_stall); nbad++; end else chk_pass++;
      chk_total++; if (idle !== e_idle) begin $display("FAIL rnd_idle cyc%0d got %0d exp %0d", cyc, idle, e_idle); nbad++; end else chk_pass++;
      chk_total++; if (err !== merr) begin $display("FAIL rnd_err cyc%0d got %0d exp %0d", cyc, err, merr); nbad++; end else chk_pass++;
      if (cyc % 40 == 0)
        $display("random cyc%0d: RegWrite=%0d WriteRegister=%0d pending=%0d stall=%0d mismatches=%0d", cyc, RegWrite, WriteRegister, mq.size(), stall, nbad);
      // Model update at the edge.
      pre_busy = mb[issue_addr];
      if (!wbv && mq.size() > 0) begin
        mb[mq[0].a] = 0;
        void'(mq.pop_front());
      end
      if (lu_valid && e_ready && lu_addr != 31) mq.push_back('{a: lu_addr, d: lu_data});
      if (issue_en && issue_addr != 31) begin
        if (pre_busy) merr = 1;
        mb[issue_addr] = 1;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_long_op();
    test_collision();
    test_zero_reg();
    test_double_issue();
    test_same_cycle();
    test_waw();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
